// File: rtl/hamming_dist_acc.sv
`timescale 1ns/1ps
// hamming_dist_acc: streams two N-bit operands W bits per beat, accumulates
// popcount(g ^ e) into a registered counter, and pulses done with a
// registered threshold compare once all N/W beats have been accepted.
module hamming_dist_acc #(
  parameter int N      = 32,
  parameter int W      = 4,
  parameter int CNT_W  = $clog2(N + 1),
  parameter int BEAT_W = $clog2(N / W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W-1:0]     g_input,
  input  logic [W-1:0]     e_input,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             below_thr
);

  // Operand geometry must tile exactly; reject bad builds at elaboration.
  generate
    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
      $error("hamming_dist_acc: N must be a multiple of W and 1 <= W <= N");
    end
  endgenerate

  localparam int PC_W = $clog2(W + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N / W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  o_reg, o_next;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic              thr_reg, thr_next;

  logic [W-1:0]      diff;
  logic [PC_W-1:0]   pc;
  logic [CNT_W-1:0]  sum;

  // Bitwise mismatch of the two shares: one XOR per bit.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_xor
      assign diff[gi] = g_input[gi] ^ e_input[gi];
    end
  endgenerate

  // Popcount of the mismatch vector, then add to the running distance.
  always_comb begin
    pc = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + PC_W'(diff[i]);
    end
    sum = o_reg + CNT_W'(pc);
  end

  // Next-state and datapath update; everything holds unless a case changes it.
  always_comb begin
    state_next = state_reg;
    o_next     = o_reg;
    beat_next  = beat_reg;
    thr_next   = thr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          o_next     = '0;
          beat_next  = '0;
          thr_next   = 1'b0;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          o_next    = sum;
          beat_next = beat_reg + BEAT_W'(1);
          if (beat_reg == LAST_BEAT) begin
            state_next = ST_DONE;
            thr_next   = (sum <= threshold);
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          o_next     = '0;
          beat_next  = '0;
          thr_next   = 1'b0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      o_reg     <= '0;
      beat_reg  <= '0;
      thr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      o_reg     <= o_next;
      beat_reg  <= beat_next;
      thr_reg   <= thr_next;
    end
  end

  assign o         = o_reg;
  assign below_thr = thr_reg;
  assign busy      = (state_reg == ST_RUN);
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_hamming_dist_acc.sv
`timescale 1ns/1ps
// Scoreboard bench: two instances (W=4 and W=1), expected final results are
// queued at stimulus time and popped by per-instance monitors on done.
module tb_hamming_dist_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // W=4 instance
  logic       rst, start, in_valid;
  logic [3:0] g_input, e_input;
  logic [5:0] threshold, o;
  logic       busy, done, below_thr;

  // W=1 instance
  logic       rst1, start1, in_valid1;
  logic [0:0] g1, e1;
  logic [5:0] thr1, o1;
  logic       busy1, done1, below1;

  hamming_dist_acc #(.N(32), .W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .g_input(g_input), .e_input(e_input), .threshold(threshold),
    .o(o), .busy(busy), .done(done), .below_thr(below_thr)
  );

  hamming_dist_acc #(.N(32), .W(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .in_valid(in_valid1),
    .g_input(g1), .e_input(e1), .threshold(thr1),
    .o(o1), .busy(busy1), .done(done1), .below_thr(below1)
  );

  int checks = 0;
  int errors = 0;
  int done0_cnt = 0;
  logic [6:0] q0[$];
  logic [6:0] q1[$];
  logic [6:0] exp0, exp1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor for the W=4 instance
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done0_cnt++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut_unexpected_done: got o=%0d, expected no done", o);
      end else begin
        exp0 = q0.pop_front();
        chk("dut_final_o", 32'(o), 32'(exp0[6:1]));
        chk("dut_below_thr", 32'(below_thr), 32'(exp0[0]));
      end
    end
  end

  // Monitor for the W=1 instance
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_done: got o=%0d, expected no done", o1);
      end else begin
        exp1 = q1.pop_front();
        chk("dut1_final_o", 32'(o1), 32'(exp1[6:1]));
        chk("dut1_below_thr", 32'(below1), 32'(exp1[0]));
      end
    end
  end

  // Tasks assume they are entered just after a falling edge.
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat4(input logic [3:0] gv, input logic [3:0] ev);
    in_valid = 1'b1;
    g_input  = gv;
    e_input  = ev;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int running;
    int dc;
    logic [3:0] stall_pat [8];
    stall_pat = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    rst = 1'b1; start = 0; in_valid = 0; g_input = 0; e_input = 0; threshold = 0;
    rst1 = 1'b1; start1 = 0; in_valid1 = 0; g1 = 0; e1 = 0; thr1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("reset_o", 32'(o), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_below_thr", 32'(below_thr), 0);

    // Full mismatch: 8 x 4 bits -> 32, threshold 16 -> not below
    threshold = 6'd16;
    q0.push_back({6'd32, 1'b0});
    start_run();
    chk("full_busy_run", 32'(busy), 1);
    for (int i = 0; i < 8; i++) beat4(4'hF, 4'h0);
    chk("full_done_pulse", 32'(done), 1);
    chk("full_busy_in_done", 32'(busy), 0);
    @(negedge clk);
    chk("full_done_one_cycle", 32'(done), 0);
    chk("full_o_hold_idle", 32'(o), 32);

    // Stalled mixed data: total 1+2+3+4 = 10, threshold 10 -> below
    threshold = 6'd10;
    q0.push_back({6'd10, 1'b1});
    dc = done0_cnt;
    start_run();
    chk("stall_cleared_o", 32'(o), 0);
    running = 0;
    for (int i = 0; i < 8; i++) begin
      beat4(stall_pat[i], 4'h0);
      running += $countones(stall_pat[i]);
      if (i < 7) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("stall_gap_b%0d_c%0d", i, k), 32'(o), 32'(running));
          @(negedge clk);
        end
      end
    end
    repeat (3) @(negedge clk);
    chk("stall_done_count", 32'(done0_cnt - dc), 1);

    // Ignored controls: in_valid in IDLE, start mid-run
    for (int k = 0; k < 4; k++) begin
      in_valid = k[0]; g_input = 4'hF; e_input = 4'h0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("idle_valid_ignored_o", 32'(o), 10);
    chk("idle_busy_low", 32'(busy), 0);
    threshold = 6'd15;
    q0.push_back({6'd16, 1'b0});
    start_run();
    for (int i = 0; i < 3; i++) beat4(4'b1010, 4'b0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrun_start_o", 32'(o), 6);
    chk("midrun_start_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) beat4(4'b0101, 4'b0000);
    chk("ignored_done", 32'(done), 1);
    @(negedge clk);

    // Back-to-back: 32 then 0 with threshold 0 -> below
    threshold = 6'd16;
    q0.push_back({6'd32, 1'b0});
    start_run();
    for (int i = 0; i < 8; i++) beat4(4'h0, 4'hF);
    chk("b2b_first_done", 32'(done), 1);
    threshold = 6'd0;
    q0.push_back({6'd0, 1'b1});
    start_run();
    chk("b2b_o_cleared", 32'(o), 0);
    chk("b2b_busy_immediate", 32'(busy), 1);
    for (int i = 0; i < 8; i++) beat4(4'h5, 4'h5);
    chk("b2b_second_done", 32'(done), 1);
    @(negedge clk);

    // W=1: reset after beat 17, then 32 alternating beats -> 16
    thr1 = 6'd20;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid1 = 1'b1; g1 = 1'b1; e1 = 1'b0;
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    chk("w1_before_reset_o", 32'(o1), 17);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("w1_reset_o", 32'(o1), 0);
    chk("w1_reset_busy", 32'(busy1), 0);
    chk("w1_reset_done", 32'(done1), 0);
    chk("w1_reset_below", 32'(below1), 0);
    thr1 = 6'd16;
    q1.push_back({6'd16, 1'b1});
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      in_valid1 = 1'b1; g1 = i[0]; e1 = 1'b0;
      @(negedge clk);
      if (i == 30) chk("w1_no_early_done", 32'(done1), 0);
    end
    in_valid1 = 1'b0;
    chk("w1_done_after_32", 32'(done1), 1);
    repeat (2) @(negedge clk);

    chk("dut_queue_drained", 32'(q0.size()), 0);
    chk("dut1_queue_drained", 32'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
